// File: rtl/tamagotchi_pkg.sv
// Shared button indices, default timing constants and the fixed-priority event
// arbiter used by the tamagotchi button conditioner and tamagotchi_fsm.
package tamagotchi_pkg;

    localparam int unsigned N_BTN         = 5;
    localparam int unsigned BTN_SALUD     = 0;
    localparam int unsigned BTN_ENERGIA   = 1;
    localparam int unsigned BTN_HAMBRE    = 2;
    localparam int unsigned BTN_DIVERSION = 3;
    localparam int unsigned BTN_TEST      = 4;

    localparam int unsigned DEFAULT_DEBOUNCE_CYC = 50000;
    localparam int unsigned DEFAULT_LONG_CYC     = 250000000;

    typedef logic [N_BTN-1:0] btn_vec_t;

    // One-hot grant: salud > hambre > energia > diversion > test.
    function automatic btn_vec_t arb_grant(input btn_vec_t pend);
        btn_vec_t g;
        g = '0;
        if (pend[BTN_SALUD])          g[BTN_SALUD]     = 1'b1;
        else if (pend[BTN_HAMBRE])    g[BTN_HAMBRE]    = 1'b1;
        else if (pend[BTN_ENERGIA])   g[BTN_ENERGIA]   = 1'b1;
        else if (pend[BTN_DIVERSION]) g[BTN_DIVERSION] = 1'b1;
        else if (pend[BTN_TEST])      g[BTN_TEST]      = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer, counter debounce and registered rising-edge pulse.
module btn_debounce
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          prev_q, prev_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        sync1_d  = raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        prev_d   = stable_q;
        rise_d   = stable_q & ~prev_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/tamagotchi_btn_cond.sv
// Button conditioner: debounced levels plus one-event-per-cycle arbitration.
// Define TAMAGOTCHI_LONGPRESS_EN to make btn_test a long-press (LONG_CYC) button.
module tamagotchi_btn_cond
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEFAULT_LONG_CYC
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       btn_salud,
    input  logic       btn_energia,
    input  logic       btn_hambre,
    input  logic       btn_diversion,
    input  logic       btn_test,
    output logic       evt_salud,
    output logic       evt_energia,
    output logic       evt_hambre,
    output logic       evt_diversion,
    output logic       evt_test,
    output logic [4:0] btn_level
);

    if (DEBOUNCE_CYC < 2 || LONG_CYC < 1) begin : g_param_check
        $error("tamagotchi_btn_cond: DEBOUNCE_CYC must be >= 2 and LONG_CYC >= 1");
    end

    btn_vec_t raw;
    btn_vec_t level;
    btn_vec_t rise;
    btn_vec_t set_v;
    btn_vec_t grant;
    btn_vec_t pend_q, pend_d;
    btn_vec_t evt_q, evt_d;

    assign raw = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (btn_reset),
            .raw_i  (raw[i]),
            .level_o(level[i]),
            .rise_o (rise[i])
        );
    end

`ifdef TAMAGOTCHI_LONGPRESS_EN
    localparam int unsigned   LW        = $clog2(LONG_CYC + 1);
    localparam logic [LW-1:0] LONG_TERM = LW'(LONG_CYC);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_hit;

    // Saturating hold counter; the hit fires only on the step into LONG_CYC.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_hit   = 1'b0;
        if (!level[BTN_TEST]) begin
            long_cnt_d = '0;
        end else if (long_cnt_q != LONG_TERM) begin
            long_cnt_d = long_cnt_q + 1'b1;
            long_hit   = (long_cnt_q == LONG_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            long_cnt_q <= '0;
        end else begin
            long_cnt_q <= long_cnt_d;
        end
    end

    always_comb begin
        set_v           = rise & ~(btn_vec_t'(1) << BTN_TEST);
        set_v[BTN_TEST] = long_hit;
    end
`else
    assign set_v = rise;
`endif

    // A rise on an already-pending button folds into that flag.
    always_comb begin
        grant  = arb_grant(pend_q);
        pend_d = (pend_q | set_v) & ~grant;
        evt_d  = grant;
    end

    always_ff @(posedge clk) begin
        if (!btn_reset) begin
            pend_q <= '0;
            evt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            evt_q  <= evt_d;
        end
    end

    assign evt_salud     = evt_q[BTN_SALUD];
    assign evt_energia   = evt_q[BTN_ENERGIA];
    assign evt_hambre    = evt_q[BTN_HAMBRE];
    assign evt_diversion = evt_q[BTN_DIVERSION];
    assign evt_test      = evt_q[BTN_TEST];
    assign btn_level     = level;

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Table-driven bench for tamagotchi_btn_cond with an event scoreboard.
module tb_tamagotchi_btn_cond;

    localparam int unsigned D = 4;
    localparam int unsigned L = 10;
`ifdef TAMAGOTCHI_LONGPRESS_EN
    localparam bit LONGPRESS = 1'b1;
`else
    localparam bit LONGPRESS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       btn_reset;
    logic [4:0] raw;
    logic       evt_salud, evt_energia, evt_hambre, evt_diversion, evt_test;
    logic [4:0] btn_level;
    logic [4:0] evt_vec;

    always #5 clk = ~clk;

    tamagotchi_btn_cond #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L)
    ) dut (
        .clk          (clk),
        .btn_reset    (btn_reset),
        .btn_salud    (raw[0]),
        .btn_energia  (raw[1]),
        .btn_hambre   (raw[2]),
        .btn_diversion(raw[3]),
        .btn_test     (raw[4]),
        .evt_salud    (evt_salud),
        .evt_energia  (evt_energia),
        .evt_hambre   (evt_hambre),
        .evt_diversion(evt_diversion),
        .evt_test     (evt_test),
        .btn_level    (btn_level)
    );

    assign evt_vec = {evt_test, evt_diversion, evt_hambre, evt_energia, evt_salud};

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [4:0]  evt;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [4:0]  press;
        int unsigned hold;
        string       name;
    } vec_t;
    vec_t vecs[10];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every event must be one-hot and match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (evt_vec != 5'b0) begin
            check("evt_onehot", 32'($countones(evt_vec)), 32'd1);
            if (sb.size() == 0) begin
                check("evt_unexpected", 32'(evt_vec), 32'd0);
            end else begin
                e = sb.pop_front();
                check("evt_which", 32'(evt_vec), 32'(e.evt));
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    // Model: pending-set edge per button, then a priority arbiter one edge later.
    task automatic push_expected(input logic [4:0] press, input int unsigned hold,
                                 input int unsigned p);
        int unsigned pe[5];
        int unsigned prio[5];
        logic [4:0]  has;
        logic [4:0]  pend;
        logic [4:0]  one;
        bit          found;
        prio = '{0, 2, 1, 3, 4};
        has  = '0;
        pend = '0;
        one  = 5'd1;
        for (int i = 0; i < 5; i++) begin
            pe[i] = 0;
            if (press[i]) begin
                if (i == 4 && LONGPRESS) begin
                    if (hold >= L) begin has[i] = 1'b1; pe[i] = p + D + L + 1; end
                end else if (hold >= D) begin
                    has[i] = 1'b1; pe[i] = p + D + 3;
                end
            end
        end
        for (int unsigned t = p; t < p + D + L + 40; t++) begin
            found = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (!found && pend[prio[k]]) begin
                    sb.push_back('{evt: one << prio[k], cyc: t});
                    pend[prio[k]] = 1'b0;
                    found = 1'b1;
                end
            end
            for (int i = 0; i < 5; i++) if (has[i] && pe[i] == t) pend[i] = 1'b1;
        end
    endtask

    task automatic run_vector(input logic [4:0] press, input int unsigned hold, input string name);
        int unsigned p, last;
        bit seen_level;
        seen_level = 1'b0;
        @(negedge clk);
        p = cyc + 1;
        push_expected(press, hold, p);
        raw  = press;
        last = p + hold + D + L + 20;
        while (cyc < last) begin
            if (cyc == p + hold - 1) raw = '0;
            if (btn_level != 5'b0) seen_level = 1'b1;
            if (cyc == p + D + 1) check({name, "_level"}, 32'(btn_level), (hold >= D) ? 32'(press) : 32'd0);
            @(negedge clk);
        end
        check({name, "_level_seen"}, 32'(seen_level), (hold >= D) ? 32'd1 : 32'd0);
        check({name, "_missing_evts"}, sb.size(), 32'd0);
        check({name, "_level_released"}, 32'(btn_level), 32'd0);
        sb.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned p, e, r;
        vecs[0] = '{5'b00001, 10, "salud_10"};
        vecs[1] = '{5'b00100, 2,  "hambre_glitch2"};
        vecs[2] = '{5'b01101, 10, "sal_ham_div"};
        vecs[3] = '{5'b00010, 4,  "energia_min"};
        vecs[4] = '{5'b01000, 3,  "div_glitch3"};
        vecs[5] = '{5'b11111, 10, "all_five"};
        vecs[6] = '{5'b10000, 20, "test_20"};
        vecs[7] = '{5'b10000, 8,  "test_8"};
        vecs[8] = '{5'b10000, 10, "test_10"};
        vecs[9] = '{5'b10000, 9,  "test_9"};

        // Raw buttons held high throughout reset must leave no trace.
        btn_reset = 1'b0;
        raw       = '1;
        repeat (4) @(negedge clk);
        check("reset_evt", 32'(evt_vec), 32'd0);
        check("reset_level", 32'(btn_level), 32'd0);
        raw       = '0;
        btn_reset = 1'b1;
        repeat (D + 8) @(negedge clk);
        check("post_reset_level", 32'(btn_level), 32'd0);

        for (int i = 0; i < 10; i++) run_vector(vecs[i].press, vecs[i].hold, vecs[i].name);

        // Reset pulse while salud is debounced-high and energia is mid-debounce.
        @(negedge clk);
        p = cyc + 1;
        push_expected(5'b00001, 100, p);
        raw[0] = 1'b1;
        while (cyc < p + D + 6) @(negedge clk);
        e = cyc + 1;
        raw[1] = 1'b1;
        while (cyc < e + 1) @(negedge clk);
        btn_reset = 1'b0;
        @(negedge clk);
        r = cyc;
        check("midreset_evt", 32'(evt_vec), 32'd0);
        check("midreset_level", 32'(btn_level), 32'd0);
        check("midreset_sb_drained", sb.size(), 32'd0);
        sb.delete();
        btn_reset = 1'b1;
        push_expected(5'b00011, 100, r + 1);
        while (cyc < r + D + 12) @(negedge clk);
        check("after_reset_level", 32'(btn_level), 32'd3);
        raw = '0;
        repeat (2 * D + 10) @(negedge clk);
        check("after_reset_missing_evts", sb.size(), 32'd0);
        check("after_reset_released", 32'(btn_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
